writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final RV32I pipeline stage (MEM/WB register plus writeback select). Sits directly upstream of the register file and drives its Rd, Write_data and RegWrite inputs.
- Captures the MEM-stage result and selects the writeback source: ALU, load, PC+4 or immediate.
- Performs load byte/halfword extraction with sign or zero extension, and suppresses illegal or misaligned writes.
- Counts retired instructions and load-misalignment events.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, width of the retire counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  kill the entry being captured this cycle
- in_valid  in  1  MEM stage presents a valid instruction
- in_rd  in  5  destination register index
- in_reg_write  in  1  instruction writes a register
- in_wb_sel  in  2  writeback source: 0=ALU, 1=load, 2=PC+4, 3=imm
- in_alu_result  in  XLEN  ALU result
- in_load_data  in  XLEN  raw aligned memory word
- in_funct3  in  3  load type: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU
- in_addr_lo  in  2  effective address bits [1:0]
- in_pc_plus4  in  XLEN  link value
- in_imm  in  XLEN  U-type immediate (LUI)
- Rd  out  5  to register file
- Write_data  out  XLEN  to register file
- RegWrite  out  1  to register file
- wb_valid  out  1  a valid instruction retires this cycle
- ld_misalign  out  1  one-cycle flag: the retiring load was misaligned or illegal
- instret  out  CNT_W  retired-instruction count
- misalign_cnt  out  16  saturating count of misaligned or illegal loads

Behaviour:
- Reset: asynchronous, active-low. While rst=0, all outputs are 0 (Rd, Write_data, RegWrite, wb_valid, ld_misalign, instret, misalign_cnt). Release is synchronous to clk.
- Latency: 1 cycle. Inputs sampled at posedge N appear on registered outputs after posedge N.
- Outputs are pure flops. Source selection and load extension are combinational before the register.
- Capture at every posedge:
  - wb_valid <= in_valid & ~flush.
  - flush=1 forces a bubble: wb_valid=0, RegWrite=0, ld_misalign=0. Rd and Write_data may update but are don't-care.
- Load extraction (in_wb_sel=1):
  - Byte: select lane in_addr_lo.
  - Halfword: select lane in_addr_lo[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word as-is.
- Misaligned or illegal load (in_wb_sel=1 and any of):
  - LH or LHU with in_addr_lo[0]=1
  - LW with in_addr_lo≠0
  - funct3 of 3, 6 or 7
  - Required response: RegWrite=0, ld_misalign=1 for one cycle, misalign_cnt+1 (saturates at 0xFFFF). wb_valid stays 1.
- RegWrite <= in_valid & ~flush & in_reg_write & (in_rd≠0) & ~misaligned. Writes to x0 are never issued.
- instret increments by 1 on each cycle the registered wb_valid is 1. Wraps modulo 2^CNT_W.
- Simultaneous events:
  - flush together with a misaligned load: flush wins; no flag, no count.
  - Reset mid-operation: the in-flight entry is dropped and counters clear.
- Non-load paths ignore in_funct3 and in_addr_lo.

Decomposition:
- Shared package rv_pkg:
  - WB_ALU/WB_LOAD/WB_PC4/WB_IMM encodings
  - funct3 load constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - XLEN default
- One sub-module, load_extend: purely combinational (in_load_data, in_funct3, in_addr_lo) -> (data, misaligned).

Test Plan:
- Reset, then in_valid=1, wb_sel=0, alu=0x0000_1234, rd=5, reg_write=1 -> next cycle Rd=5, Write_data=0x0000_1234, RegWrite=1, wb_valid=1, instret=1.
- LB: raw=0x80FF_7F01, addr_lo=3 -> Write_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080. LH with addr_lo=2 -> 0xFFFF_80FF.
- LW with addr_lo=2, rd=7 -> RegWrite=0, ld_misalign=1 for 1 cycle, misalign_cnt=1, wb_valid=1.
- rd=0 with reg_write=1, and flush=1 with a valid ALU op -> RegWrite=0 in both cases. wb_valid=0 on the flush cycle only; instret advances only for the rd=0 case.
- wb_sel=2, pc_plus4=0x0000_0104, rd=1 -> Write_data=0x0000_0104. wb_sel=3, imm=0xABCD_E000 -> Write_data=0xABCD_E000.
- 10 back-to-back valid ops, assert rst low mid-stream -> all outputs 0 immediately (asynchronous). After release, 3 ops -> instret=3.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I writeback encodings: writeback source select and load funct3 values.
package rv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction with sign/zero extension and alignment check.
module load_extend
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] load_data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = load_data[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? load_data[31:16] : load_data[15:0];

  always_comb begin
    data       = load_data;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH: begin
        data       = {{(XLEN-16){half_lane[15]}}, half_lane};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_lane};
        misaligned = addr_lo[0];
      end
      F3_LW:  misaligned = (addr_lo != 2'd0);
      // funct3 3, 6, 7 are not loads in RV32I
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback source select, write suppression and retire counters.
module writeback_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_load_data,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  in_imm,
  output logic [4:0]       Rd,
  output logic [XLEN-1:0]  Write_data,
  output logic             RegWrite,
  output logic             wb_valid,
  output logic             ld_misalign,
  output logic [CNT_W-1:0] instret,
  output logic [15:0]      misalign_cnt
);

  logic [XLEN-1:0] ld_data;
  logic            ld_bad;
  logic [XLEN-1:0] sel_data;
  logic            take;
  logic            bad_load;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .load_data  (in_load_data),
    .funct3     (in_funct3),
    .addr_lo    (in_addr_lo),
    .data       (ld_data),
    .misaligned (ld_bad)
  );

  always_comb begin
    sel_data = in_alu_result;
    case (in_wb_sel)
      WB_LOAD: sel_data = ld_data;
      WB_PC4:  sel_data = in_pc_plus4;
      WB_IMM:  sel_data = in_imm;
      default: sel_data = in_alu_result;
    endcase
  end

  assign take     = in_valid & ~flush;
  assign bad_load = (in_wb_sel == WB_LOAD) & ld_bad;

  // Counters include the instruction retiring on the same edge, so they agree with wb_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Rd           <= '0;
      Write_data   <= '0;
      RegWrite     <= 1'b0;
      wb_valid     <= 1'b0;
      ld_misalign  <= 1'b0;
      instret      <= '0;
      misalign_cnt <= '0;
    end else begin
      Rd          <= in_rd;
      Write_data  <= sel_data;
      wb_valid    <= take;
      RegWrite    <= take & in_reg_write & (in_rd != 5'd0) & ~bad_load;
      ld_misalign <= take & bad_load;
      instret     <= instret + CNT_W'(take);
      if (take && bad_load && misalign_cnt != 16'hFFFF)
        misalign_cnt <= misalign_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage against a behavioural writeback model.
module tb_writeback_stage;

  typedef struct {
    bit          valid;
    bit          flush;
    bit [4:0]    rd;
    bit          rw;
    bit [1:0]    sel;
    bit [31:0]   alu;
    bit [31:0]   ld;
    bit [2:0]    f3;
    bit [1:0]    addr;
    bit [31:0]   pc4;
    bit [31:0]   imm;
  } txn_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        flush = 0, in_valid = 0, in_reg_write = 0;
  logic [4:0]  in_rd = 0;
  logic [1:0]  in_wb_sel = 0, in_addr_lo = 0;
  logic [2:0]  in_funct3 = 0;
  logic [31:0] in_alu_result = 0, in_load_data = 0, in_pc_plus4 = 0, in_imm = 0;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic        RegWrite, wb_valid, ld_misalign;
  logic [63:0] instret;
  logic [15:0] misalign_cnt;

  writeback_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
    .in_load_data(in_load_data), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .Rd(Rd), .Write_data(Write_data),
    .RegWrite(RegWrite), .wb_valid(wb_valid), .ld_misalign(ld_misalign),
    .instret(instret), .misalign_cnt(misalign_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          exp_valid = 0, exp_rw = 0, exp_mis = 0, exp_dchk = 1;
  bit [4:0]    exp_rd = 0;
  bit [31:0]   exp_data = 0;
  bit [63:0]   m_instret = 0;
  int          m_mcnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // What the register file should see, from the ISA load rules.
  function automatic bit [31:0] model_data(txn_t t, output bit bad);
    bit [31:0] sh;
    bit [7:0]  b;
    bit [15:0] h;
    bad = 0;
    case (t.sel)
      2'd0: return t.alu;
      2'd2: return t.pc4;
      2'd3: return t.imm;
      default: ;
    endcase
    sh = t.ld >> (8 * t.addr);
    b  = sh[7:0];
    sh = t.ld >> (16 * t.addr[1]);
    h  = sh[15:0];
    case (t.f3)
      3'd0: return 32'($signed(b));
      3'd4: return {24'd0, b};
      3'd1: begin bad = (t.addr % 2) != 0; return 32'($signed(h)); end
      3'd5: begin bad = (t.addr % 2) != 0; return {16'd0, h}; end
      3'd2: begin bad = t.addr != 0; return t.ld; end
      default: begin bad = 1; return t.ld; end
    endcase
  endfunction

  task automatic model_reset();
    m_instret = 0; m_mcnt = 0;
    exp_valid = 0; exp_rw = 0; exp_mis = 0; exp_dchk = 1; exp_rd = 0; exp_data = 0;
  endtask

  // Drive one transaction, let it be captured, update the expectation; returns at posedge+2.
  task automatic apply(txn_t t);
    bit bad, take;
    bit [31:0] d;
    flush = t.flush; in_valid = t.valid; in_rd = t.rd; in_reg_write = t.rw;
    in_wb_sel = t.sel; in_alu_result = t.alu; in_load_data = t.ld; in_funct3 = t.f3;
    in_addr_lo = t.addr; in_pc_plus4 = t.pc4; in_imm = t.imm;
    d = model_data(t, bad);
    if (t.sel != 2'd1) bad = 0;
    take = t.valid && !t.flush;
    @(posedge clk);
    if (rst) begin
      exp_valid = take;
      exp_rw    = take && t.rw && t.rd != 0 && !bad;
      exp_mis   = take && bad;
      exp_dchk  = take && !bad;
      exp_rd    = t.rd;
      exp_data  = d;
      if (take) m_instret++;
      if (take && bad && m_mcnt < 16'hFFFF) m_mcnt++;
    end
    #2;
  endtask

  function automatic txn_t blank();
    txn_t t;
    t.valid = 1; t.flush = 0; t.rd = 5'd1; t.rw = 1; t.sel = 2'd0;
    t.alu = 0; t.ld = 0; t.f3 = 0; t.addr = 0; t.pc4 = 0; t.imm = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.valid = ($urandom_range(0, 9) < 8);
    t.flush = ($urandom_range(0, 9) == 0);
    t.rd    = 5'($urandom_range(0, 31));
    t.rw    = ($urandom_range(0, 3) != 0);
    t.sel   = 2'($urandom_range(0, 3));
    t.alu   = $urandom; t.ld = $urandom; t.pc4 = $urandom; t.imm = $urandom;
    t.f3    = 3'($urandom_range(0, 7));
    t.addr  = 2'($urandom_range(0, 3));
    return t;
  endfunction

  always @(negedge clk) begin
    chk("wb_valid", 64'(wb_valid), 64'(exp_valid));
    chk("RegWrite", 64'(RegWrite), 64'(exp_rw));
    chk("ld_misalign", 64'(ld_misalign), 64'(exp_mis));
    chk("instret", instret, m_instret);
    chk("misalign_cnt", 64'(misalign_cnt), 64'(m_mcnt));
    if (exp_dchk) begin
      chk("Rd", 64'(Rd), 64'(exp_rd));
      chk("Write_data", 64'(Write_data), 64'(exp_data));
    end
  end

  initial begin
    txn_t t;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", {Rd, Write_data, RegWrite, wb_valid, ld_misalign}, 0);
    chk("reset_instret", instret, 0);
    chk("reset_mcnt", 64'(misalign_cnt), 0);
    rst = 1;

    t = blank(); t.rd = 5; t.alu = 32'h0000_1234; apply(t);
    chk("alu_rd", 64'(Rd), 5);
    chk("alu_data", 64'(Write_data), 64'h1234);
    chk("alu_rw_valid", {RegWrite, wb_valid}, 2'b11);
    chk("alu_instret", instret, 1);

    t = blank(); t.sel = 1; t.ld = 32'h80FF_7F01; t.addr = 3; t.f3 = 0; apply(t);
    chk("lb_data", 64'(Write_data), 64'hFFFF_FF80);
    t.f3 = 4; apply(t);
    chk("lbu_data", 64'(Write_data), 64'h0000_0080);
    t.f3 = 1; t.addr = 2; apply(t);
    chk("lh_data", 64'(Write_data), 64'hFFFF_80FF);

    t = blank(); t.sel = 1; t.f3 = 2; t.addr = 2; t.rd = 7; apply(t);
    chk("lw_mis_flags", {RegWrite, ld_misalign, wb_valid}, 3'b011);
    chk("lw_mis_cnt", 64'(misalign_cnt), 1);
    t = blank(); apply(t);
    chk("mis_one_cycle", 64'(ld_misalign), 0);

    t = blank(); t.rd = 0; apply(t);
    chk("x0_rw_valid", {RegWrite, wb_valid}, 2'b01);
    chk("x0_instret", instret, 7);
    t = blank(); t.flush = 1; apply(t);
    chk("flush_rw_valid", {RegWrite, wb_valid}, 2'b00);
    chk("flush_instret", instret, 7);
    t = blank(); t.flush = 1; t.sel = 1; t.f3 = 7; apply(t);
    chk("flush_mis", {ld_misalign, misalign_cnt}, 0 | 17'd1);

    t = blank(); t.sel = 2; t.pc4 = 32'h0000_0104; apply(t);
    chk("pc4_data", 64'(Write_data), 64'h0104);
    t.sel = 3; t.imm = 32'hABCD_E000; apply(t);
    chk("imm_data", 64'(Write_data), 64'hABCD_E000);

    for (int i = 0; i < 3000; i++) apply(rand_txn());

    for (int i = 0; i < 5; i++) begin t = blank(); t.alu = $urandom; apply(t); end
    rst = 0;
    model_reset();
    #1;
    chk("async_reset_outputs", {Rd, Write_data, RegWrite, wb_valid, ld_misalign}, 0);
    chk("async_reset_cnts", {instret, misalign_cnt} == 0, 1);
    for (int i = 0; i < 5; i++) begin t = blank(); apply(t); end
    rst = 1;
    for (int i = 0; i < 3; i++) begin t = blank(); t.alu = $urandom; apply(t); end
    chk("post_reset_instret", instret, 3);

    for (int i = 0; i < 500; i++) apply(rand_txn());
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
